// File: rtl/data_mem_responder.sv
// Data-memory slave for the core's data bus: word-organised RAM with byte-lane
// steering, programmable wait states and a registered active-low acknowledge.
//
// state  | meaning
// IDLE   | waiting for MREQ; request registers loaded on the capturing edge
// WAIT   | counting down wait states; captured request held, bus inputs ignored
// ACK    | response computed; ACKD_n/ERR/DDT_* driven for the following cycle
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    input  logic [31:0] DDT_in,
    output logic [31:0] DDT_out,
    output logic        DDT_oe,
    output logic        ACKD_n,
    output logic        ERR
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    logic [31:0]      r_mem [DEPTH_WORDS];

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_write;
    logic [1:0]       r_size;
    logic [1:0]       r_lane;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_err;

    logic [31:0]      r_ddt_out;
    logic             r_ddt_oe;
    logic             r_ackd_n;
    logic             r_err_out;

    logic             w_in_range;
    logic             w_misalign;
    logic             w_req_err;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_rd_shift;
    logic [31:0]      w_load_data;
    logic [31:0]      w_wr_lanes;
    logic [3:0]       w_wr_be;
    logic             w_commit;

    // BASE_ADDR is aligned to the RAM size, so the range test is a tag compare
    // and the word index is taken straight from the address bits.
    assign w_in_range = (DAD[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    assign w_misalign = ((SIZE == SZ_HALF) && DAD[0]) ||
                        ((SIZE == SZ_WORD) && (DAD[1:0] != 2'b00));
    assign w_req_err  = (SIZE == 2'b11) || w_misalign || !w_in_range;

    assign w_rd_word  = r_mem[r_idx];
    assign w_rd_shift = w_rd_word >> {r_lane, 3'b000};

    always_comb begin
        w_load_data = 32'd0;
        case (r_size)
            SZ_BYTE: w_load_data = {24'd0, w_rd_shift[7:0]};
            SZ_HALF: w_load_data = {16'd0, w_rd_shift[15:0]};
            SZ_WORD: w_load_data = w_rd_word;
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        w_wr_lanes = r_wdata;
        w_wr_be    = 4'b0000;
        case (r_size)
            SZ_BYTE: begin
                w_wr_lanes = {4{r_wdata[7:0]}};
                w_wr_be    = 4'b0001 << r_lane;
            end
            SZ_HALF: begin
                w_wr_lanes = {2{r_wdata[15:0]}};
                w_wr_be    = r_lane[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                w_wr_lanes = r_wdata;
                w_wr_be    = 4'b1111;
            end
            default: begin
                w_wr_lanes = r_wdata;
                w_wr_be    = 4'b0000;
            end
        endcase
    end

    // Store commits on the edge leaving ACK; a reset on that edge drops it.
    assign w_commit = !rst && (r_state == S_ACK) && r_write && !r_err;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= w_wr_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_size    <= 2'b00;
            r_lane    <= 2'b00;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            r_err     <= 1'b0;
            r_ddt_out <= 32'd0;
            r_ddt_oe  <= 1'b0;
            r_ackd_n  <= 1'b1;
            r_err_out <= 1'b0;
        end else begin
            r_ddt_out <= 32'd0;
            r_ddt_oe  <= 1'b0;
            r_ackd_n  <= 1'b1;
            r_err_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (MREQ) begin
                        r_write <= WRITE;
                        r_size  <= SIZE;
                        r_lane  <= DAD[1:0];
                        r_idx   <= DAD[IDX_W+1:2];
                        r_wdata <= DDT_in;
                        r_err   <= w_req_err;
                        r_cnt   <= WAIT_LOAD;
                        r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_ackd_n  <= 1'b0;
                    r_err_out <= r_err;
                    if (!r_err && !r_write) begin
                        r_ddt_oe  <= 1'b1;
                        r_ddt_out <= w_load_data;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DDT_out = r_ddt_out;
    assign DDT_oe  = r_ddt_oe;
    assign ACKD_n  = r_ackd_n;
    assign ERR     = r_err_out;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: four instances with different wait
// counts; stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_data_mem_responder;

    localparam int N_DUT = 4;

    logic        clk = 1'b0;
    logic        rst  [N_DUT];
    logic        mreq [N_DUT];
    logic        wr   [N_DUT];
    logic [1:0]  sz   [N_DUT];
    logic [31:0] dad  [N_DUT];
    logic [31:0] din  [N_DUT];
    logic [31:0] dout [N_DUT];
    logic        oe   [N_DUT];
    logic        ackn [N_DUT];
    logic        err  [N_DUT];

    always #5 clk = ~clk;

    function automatic int wc(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 5 : 3;
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (32'h0002_0000),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk    (clk),
            .rst    (rst[g]),
            .MREQ   (mreq[g]),
            .WRITE  (wr[g]),
            .SIZE   (sz[g]),
            .DAD    (dad[g]),
            .DDT_in (din[g]),
            .DDT_out(dout[g]),
            .DDT_oe (oe[g]),
            .ACKD_n (ackn[g]),
            .ERR    (err[g])
        );
    end

    typedef struct {
        int          inst;
        bit          err;
        bit          oe;
        logic [31:0] data;
        int          ack_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N_DUT; i++) begin
                checks++;
                if (ackn[i] === 1'b0) begin
                    if (sb.size() == 0 || sb[0].inst != i) begin
                        errors++;
                        $display("FAIL unexpected_ack dut%0d at cyc %0d (no ack expected)", i, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (err[i] !== e.err || oe[i] !== e.oe || dout[i] !== e.data || cyc != e.ack_cyc) begin
                            errors++;
                            $display("FAIL %s dut%0d: got err=%0b oe=%0b data=%h cyc=%0d, want err=%0b oe=%0b data=%h cyc=%0d",
                                     e.name, i, err[i], oe[i], dout[i], cyc, e.err, e.oe, e.data, e.ack_cyc);
                        end
                    end
                end else if (ackn[i] !== 1'b1 || oe[i] !== 1'b0 || err[i] !== 1'b0 || dout[i] !== 32'd0) begin
                    errors++;
                    $display("FAIL idle_outputs dut%0d cyc %0d: got ackn=%0b oe=%0b err=%0b data=%h, want 1 0 0 00000000",
                             i, cyc, ackn[i], oe[i], err[i], dout[i]);
                end
            end
        end
    end

    task automatic txn(input int i, input bit w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit e_err, input logic [31:0] e_data,
                       input string nm, input bit chg = 1'b0);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        mreq[i] = 1'b1; wr[i] = w; sz[i] = s; dad[i] = a; din[i] = d;
        @(posedge clk);
        n         = cyc;
        e.inst    = i;
        e.err     = e_err;
        e.oe      = !e_err && !w;
        e.data    = (e_err || w) ? 32'd0 : e_data;
        e.ack_cyc = n + 2 + wc(i);
        e.name    = nm;
        sb.push_back(e);
        @(negedge clk);
        mreq[i] = 1'b0;
        if (chg) begin
            dad[i] = a + 32'd4; din[i] = ~d; wr[i] = ~w; sz[i] = 2'b00;
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (ackn[i] === 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout dut%0d: got no ack within 40 cycles, want ack at cyc %0d", nm, i, e.ack_cyc);
        end
    endtask

    task automatic burst(input int i, input logic [31:0] a, input logic [31:0] e_data,
                         input int n, input string nm);
        exp_t e;
        int   p;
        int   c0;
        p = wc(i) + 2;
        @(negedge clk);
        mreq[i] = 1'b1; wr[i] = 1'b0; sz[i] = 2'b10; dad[i] = a;
        @(posedge clk);
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            e.inst    = i;
            e.err     = 1'b0;
            e.oe      = 1'b1;
            e.data    = e_data;
            e.ack_cyc = c0 + 2 + wc(i) + k * p;
            e.name    = nm;
            sb.push_back(e);
        end
        repeat ((n - 1) * p) @(posedge clk);
        @(negedge clk);
        mreq[i] = 1'b0;
        repeat (p + 4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing dut%0d: got %0d acks outstanding, want 0", nm, i, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got simulation still running, want finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            rst[i] = 1'b1; mreq[i] = 1'b0; wr[i] = 1'b0;
            sz[i] = 2'b00; dad[i] = 32'd0; din[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            checks++;
            if (ackn[i] !== 1'b1 || err[i] !== 1'b0 || oe[i] !== 1'b0 || dout[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got ackn=%0b err=%0b oe=%0b data=%h, want 1 0 0 00000000",
                         i, ackn[i], err[i], oe[i], dout[i]);
            end
        end
        for (int i = 0; i < N_DUT; i++) rst[i] = 1'b0;
        mon_en = 1'b1;

        // WAIT_CYCLES=1: word, byte-lane and half-word traffic
        txn(0, 1'b1, 2'b10, 32'h0002_0010, 32'hDEADBEEF, 1'b0, 32'h0,         "w1_store_word");
        txn(0, 1'b0, 2'b10, 32'h0002_0010, 32'h0,        1'b0, 32'hDEADBEEF, "w1_load_word");
        txn(0, 1'b1, 2'b10, 32'h0002_0020, 32'h11223344, 1'b0, 32'h0,         "preload_word");
        txn(0, 1'b1, 2'b00, 32'h0002_0021, 32'hFFFFFFAA, 1'b0, 32'h0,         "store_byte_l1");
        txn(0, 1'b0, 2'b10, 32'h0002_0020, 32'h0,        1'b0, 32'h1122AA44, "load_after_byte");
        txn(0, 1'b0, 2'b00, 32'h0002_0023, 32'h0,        1'b0, 32'h00000011, "load_byte_l3");
        txn(0, 1'b0, 2'b01, 32'h0002_0022, 32'h0,        1'b0, 32'h00001122, "load_half_hi");
        txn(0, 1'b1, 2'b01, 32'h0002_0022, 32'h7777BEEF, 1'b0, 32'h0,         "store_half_hi");
        txn(0, 1'b0, 2'b10, 32'h0002_0020, 32'h0,        1'b0, 32'hBEEFAA44, "load_after_half");
        txn(0, 1'b0, 2'b01, 32'h0002_0020, 32'h0,        1'b0, 32'h0000AA44, "load_half_lo");
        txn(0, 1'b0, 2'b00, 32'h0002_0021, 32'h0,        1'b0, 32'h000000AA, "load_byte_l1");

        // Rejected accesses, then readback to show RAM untouched
        txn(0, 1'b0, 2'b10, 32'h0002_0002, 32'h0,        1'b1, 32'h0, "err_word_misalign");
        txn(0, 1'b1, 2'b01, 32'h0002_0021, 32'h00005555, 1'b1, 32'h0, "err_half_misalign_st");
        txn(0, 1'b0, 2'b11, 32'h0002_0020, 32'h0,        1'b1, 32'h0, "err_size11_ld");
        txn(0, 1'b1, 2'b11, 32'h0002_0020, 32'h0,        1'b1, 32'h0, "err_size11_st");
        txn(0, 1'b0, 2'b10, 32'h0001_FFFC, 32'h0,        1'b1, 32'h0, "err_below_base_ld");
        txn(0, 1'b1, 2'b10, 32'h0001_FFFC, 32'h99999999, 1'b1, 32'h0, "err_below_base_st");
        txn(0, 1'b1, 2'b10, 32'h0002_0000, 32'h01020304, 1'b0, 32'h0, "store_word0");
        txn(0, 1'b1, 2'b10, 32'h0002_1000, 32'hFFFFFFFF, 1'b1, 32'h0, "err_above_top_st");
        txn(0, 1'b0, 2'b10, 32'h0002_0020, 32'h0, 1'b0, 32'hBEEFAA44, "readback_after_err");
        txn(0, 1'b0, 2'b10, 32'h0002_0000, 32'h0, 1'b0, 32'h01020304, "readback_word0");
        txn(0, 1'b1, 2'b10, 32'h0002_0FFC, 32'h0BADCAFE, 1'b0, 32'h0, "store_top_word");
        txn(0, 1'b0, 2'b10, 32'h0002_0FFC, 32'h0, 1'b0, 32'h0BADCAFE, "load_top_word");
        txn(0, 1'b0, 2'b00, 32'h0002_0FFF, 32'h0, 1'b0, 32'h0000000B, "load_top_byte");

        // WAIT_CYCLES=0: single-cycle latency and two-cycle ack cadence
        txn(1, 1'b1, 2'b10, 32'h0002_0100, 32'h13579BDF, 1'b0, 32'h0, "w0_store");
        txn(1, 1'b0, 2'b10, 32'h0002_0100, 32'h0, 1'b0, 32'h13579BDF, "w0_load");
        burst(1, 32'h0002_0100, 32'h13579BDF, 3, "w0_burst");

        // WAIT_CYCLES=5: input hold during WAIT and seven-cycle cadence
        txn(2, 1'b1, 2'b10, 32'h0002_0044, 32'h00000000, 1'b0, 32'h0, "w5_clear_next");
        txn(2, 1'b1, 2'b10, 32'h0002_0040, 32'hA5A5A5A5, 1'b0, 32'h0, "w5_store_hold", 1'b1);
        txn(2, 1'b0, 2'b10, 32'h0002_0040, 32'h0, 1'b0, 32'hA5A5A5A5, "w5_load_held");
        txn(2, 1'b0, 2'b10, 32'h0002_0044, 32'h0, 1'b0, 32'h00000000, "w5_load_neighbour");
        burst(2, 32'h0002_0040, 32'hA5A5A5A5, 3, "w5_burst");

        // WAIT_CYCLES=3: reset in the second WAIT cycle drops the store
        txn(3, 1'b1, 2'b10, 32'h0002_0200, 32'hCAFEF00D, 1'b0, 32'h0, "w3_store_old");
        @(negedge clk);
        mreq[3] = 1'b1; wr[3] = 1'b1; sz[3] = 2'b10; dad[3] = 32'h0002_0200; din[3] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        mreq[3] = 1'b0;
        @(negedge clk);
        rst[3] = 1'b1;
        @(negedge clk);
        rst[3] = 1'b0;
        repeat (10) @(negedge clk);
        txn(3, 1'b0, 2'b10, 32'h0002_0200, 32'h0, 1'b0, 32'hCAFEF00D, "w3_load_after_abort");

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
